// File: rtl/instruction_fetch.sv
// RV32E fetch stage: owns the PC, reads the combinational program ROM and
// buffers up to two instructions for decode behind a valid/ready handshake.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ROM_WORDS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault,
  output logic        misalign_err
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS * 4);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic [31:0] fetch_pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        buf_fault [2];
  logic        head;
  logic [1:0]  count;

  logic        pop;
  logic        push;
  logic        tail;
  logic        fetch_fault;
  logic [31:0] fetch_word;

  assign rom_addr    = fetch_pc;
  assign id_valid    = (count != 2'd0);
  assign pop         = id_valid && id_ready;
  assign push        = !redirect_valid && ((count < 2'd2) || pop);
  // With two slots, head+count mod 2 reduces to an XOR with count's LSB.
  assign tail        = head ^ count[0];
  assign fetch_fault = (fetch_pc >= ROM_LIMIT);
  assign fetch_word  = fetch_fault ? NOP : rom_data;

  assign id_instr = id_valid ? buf_instr[head] : NOP;
  assign id_pc    = id_valid ? buf_pc[head]    : RESET_PC;
  assign id_fault = id_valid ? buf_fault[head] : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[tail]    <= fetch_pc;
      buf_instr[tail] <= fetch_word;
      buf_fault[tail] <= fetch_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      head         <= 1'b0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (|redirect_pc[1:0]);
      if (redirect_valid) begin
        // Flush wins over any push; a same-cycle pop is already owned by decode.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= 2'd0;
        head     <= 1'b0;
      end else begin
        if (push)
          fetch_pc <= fetch_pc + 32'd4;
        if (pop)
          head <= ~head;
        if (push && !pop)
          count <= count + 2'd1;
        else if (pop && !push)
          count <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a behavioural ROM
// whose words encode their own word index.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        misalign_err;

  int assertCount = 0;
  int failCount   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .ROM_WORDS(100)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_fault(id_fault), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return 32'h00C0_0000 + (a >> 2);
  endfunction

  // Out-of-range reads return garbage so NOP substitution is observable.
  assign rom_data = (rom_addr < 32'd400) ? romWord(rom_addr) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                               input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    id_ready       = rdy;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc,
                           input logic [31:0] instr, input logic fault);
    checkOutput({tag, "_valid"}, 32'(id_valid), 32'd1);
    checkOutput({tag, "_pc"},    id_pc,    pc);
    checkOutput({tag, "_instr"}, id_instr, instr);
    checkOutput({tag, "_fault"}, 32'(id_fault), 32'(fault));
  endtask

  initial begin
    logic [31:0] pcs [3];
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    #2;
    checkOutput("rst_rom_addr", rom_addr, 32'h0);
    checkOutput("rst_valid",    32'(id_valid), 32'd0);
    checkOutput("rst_instr",    id_instr, NOP);
    checkOutput("rst_pc",       id_pc, 32'h0);
    checkOutput("rst_fault",    32'(id_fault), 32'd0);
    checkOutput("rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] streaming from reset");
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkHead("stream", 32'(i * 4), romWord(32'(i * 4)), 1'b0);
    end

    $display("[TB] asynchronous reset mid-stream");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid",    32'(id_valid), 32'd0);
    checkOutput("arst_rom_addr", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkHead("restart0", 32'h0, romWord(32'h0), 1'b0);
    stepCycle();
    checkHead("restart1", 32'h4, romWord(32'h4), 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("bp_pc",       id_pc, 32'h4);
      checkOutput("bp_valid",    32'(id_valid), 32'd1);
      checkOutput("bp_rom_addr", rom_addr, 32'hC);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bp_release_pc", id_pc, 32'h4);
    pcs[0] = 32'h8; pcs[1] = 32'hC; pcs[2] = 32'h10;
    for (int i = 0; i < 3; i++) begin
      stepCycle();
      checkHead("drain", pcs[i], romWord(pcs[i]), 1'b0);
    end

    $display("[TB] misaligned redirect with full buffer");
    applyStimulus(1'b1, 32'h31, 1'b1);
    stepCycle();
    checkOutput("redir_valid",    32'(id_valid), 32'd0);
    checkOutput("redir_rom_addr", rom_addr, 32'h30);
    checkOutput("redir_misalign", 32'(misalign_err), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkHead("redir_tgt", 32'h30, romWord(32'h30), 1'b0);
    checkOutput("redir_misalign_clr", 32'(misalign_err), 32'd0);
    stepCycle();
    checkHead("redir_next", 32'h34, romWord(32'h34), 1'b0);

    $display("[TB] back-to-back redirects");
    applyStimulus(1'b1, 32'h40, 1'b1);
    stepCycle();
    applyStimulus(1'b1, 32'h80, 1'b1);
    stepCycle();
    checkOutput("b2b_valid",    32'(id_valid), 32'd0);
    checkOutput("b2b_rom_addr", rom_addr, 32'h80);
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkHead("b2b_tgt", 32'h80, romWord(32'h80), 1'b0);

    $display("[TB] out-of-range fetch");
    applyStimulus(1'b1, 32'h18C, 1'b1);
    stepCycle();
    checkOutput("oor_rom_addr", rom_addr, 32'h18C);
    checkOutput("oor_misalign", 32'(misalign_err), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkHead("oor_last", 32'h18C, 32'h00C0_0063, 1'b0);
    stepCycle();
    checkHead("oor_first", 32'h190, NOP, 1'b1);
    stepCycle();
    checkHead("oor_second", 32'h194, NOP, 1'b1);

    $display("[TB] wrap-around");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    stepCycle();
    checkOutput("wrap_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    stepCycle();
    checkHead("wrap_top", 32'hFFFF_FFFC, NOP, 1'b1);
    stepCycle();
    checkHead("wrap_zero", 32'h0, romWord(32'h0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
